// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Purpose  : Load/store responder between the decoder's memory command word
//            and a word-organised data memory using a req/ack handshake.
//            Handles byte/half/word lanes, load extension and fault flagging.
// Options  : define DMEM_TIMEOUT_EN to enable the MEM_ACK watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            DATA_MEM_READ,
  input  logic [2:0]            DATA_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  ACCESS_FAULT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-3:0] MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  output logic [3:0]            MEM_BYTE_EN,
  input  logic [31:0]           MEM_READDATA,
  input  logic                  MEM_ACK
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;

  logic        rd;
  logic        wr;
  logic        req;
  logic [2:0]  funct3;       // loads use funct3 directly; stores fold in as {0,size}
  logic        illegal_op;
  logic        misaligned;
  logic        req_fault;
  logic [3:0]  byte_en;
  logic [31:0] store_data;

  logic [2:0]  funct3_r;
  logic [1:0]  lane_r;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic        timeout;

  // Decode the command word into size, lane enables, replicated data and fault
  always_comb begin
    rd         = DATA_MEM_READ[3];
    wr         = DATA_MEM_WRITE[2];
    req        = rd | wr;
    funct3     = rd ? DATA_MEM_READ[2:0] : {1'b0, DATA_MEM_WRITE[1:0]};
    // size 11 covers load 011/111 and store 11; 110 is the remaining hole
    illegal_op = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && ADDRESS[0]) ||
                 ((funct3[1:0] == 2'b10) && (ADDRESS[1:0] != 2'b00));
    req_fault  = (rd && wr) || illegal_op || misaligned;
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << ADDRESS[1:0];
        store_data = {4{WRITE_DATA[7:0]}};
      end
      2'b01: begin
        byte_en    = 4'b0011 << {ADDRESS[1], 1'b0};
        store_data = {2{WRITE_DATA[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = WRITE_DATA;
      end
    endcase
  end

  // Stall while a new request is being accepted and for the whole memory cycle
  assign BUSYWAIT = ((state == IDLE) && req) || (state == ACCESS);

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    case (lane_r)
      2'd0:    load_byte = MEM_READDATA[7:0];
      2'd1:    load_byte = MEM_READDATA[15:8];
      2'd2:    load_byte = MEM_READDATA[23:16];
      default: load_byte = MEM_READDATA[31:24];
    endcase
    load_half = lane_r[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (funct3_r)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = MEM_READDATA;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The counter is compared one below the limit: a miss in this cycle makes it reach the limit
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS cycles spent without an ack; IDLE always precedes ACCESS, so clear there
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !MEM_ACK) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (wait_cnt == CNT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // Command sequencing with registered memory-side outputs and load result
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      READ_DATA     <= '0;
      ACCESS_FAULT  <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      MEM_BYTE_EN   <= '0;
      funct3_r      <= '0;
      lane_r        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (req_fault) begin
              state        <= DONE;
              ACCESS_FAULT <= 1'b1;
              if (rd) READ_DATA <= '0;
            end else begin
              state         <= ACCESS;
              MEM_READ      <= rd;
              MEM_WRITE     <= wr;
              MEM_ADDRESS   <= ADDRESS[ADDR_WIDTH-1:2];
              MEM_WRITEDATA <= store_data;
              MEM_BYTE_EN   <= byte_en;
              funct3_r      <= funct3;
              lane_r        <= ADDRESS[1:0];
            end
          end
        end
        ACCESS: begin
          // An ack in the limit cycle takes priority over the watchdog
          if (MEM_ACK) begin
            state     <= DONE;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (MEM_READ) READ_DATA <= load_value;
          end else if (timeout) begin
            state        <= DONE;
            MEM_READ     <= 1'b0;
            MEM_WRITE    <= 1'b0;
            ACCESS_FAULT <= 1'b1;
            if (MEM_READ) READ_DATA <= '0;
          end
        end
        DONE: begin
          // The pipeline advances on this edge, so any request seen now is stale
          state        <= IDLE;
          ACCESS_FAULT <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Purpose  : Self-checking bench for dmem_access_unit. A byte-level reference
//            model of the load/store rules predicts lanes, data and faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        ACCESS_FAULT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [29:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READDATA;
  logic        MEM_ACK;

  int          checks = 0;
  int          errors = 0;
  int          busy_cycles;
  logic [31:0] mem_ref [16];   // model's view of memory
  logic [31:0] mem_dev [16];   // memory device driven by the DUT's requests
  logic [31:0] exp_rd = 32'd0;

  always #5 CLK = ~CLK;

  dmem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .ACCESS_FAULT(ACCESS_FAULT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTE_EN(MEM_BYTE_EN),
    .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a single (non-conflicting) command
  function automatic int ref_nbytes(input logic [3:0] r, input logic [2:0] w);
    int sz;
    if (r[3]) sz = (r[1:0] == 2'd0) ? 1 : (r[1:0] == 2'd1) ? 2 : 4;
    else      sz = (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
    return sz;
  endfunction

  function automatic bit ref_fault(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a);
    if (r[3] && w[2]) return 1'b1;
    if (r[3] && (r[2:0] == 3'd3 || r[2:0] == 3'd6 || r[2:0] == 3'd7)) return 1'b1;
    if (!r[3] && w[1:0] == 2'd3) return 1'b1;
    return (a % ref_nbytes(r, w)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
    int n;
    logic [31:0] mask;
    logic [31:0] v;
    n    = ref_nbytes({1'b1, f}, 3'd0);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (word >> (8 * (a % 4))) & mask;
    if (!f[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // One complete command: request, optional memory cycle with dly ack waits, DONE, back to IDLE
  task automatic do_op(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input int dly);
    int n;
    int idx;
    logic [31:0] be_i;
    logic [31:0] exp_wd;
    idx = int'((a >> 2) % 16);
    busy_cycles = 0;
    DATA_MEM_READ = r; DATA_MEM_WRITE = w; ADDRESS = a; WRITE_DATA = wd;
    #1;
    check("busy_on_request", 32'(BUSYWAIT), 32'd1);
    if (BUSYWAIT) busy_cycles++;
    @(posedge CLK); #1;
    if (ref_fault(r, w, a)) begin
      if (r[3]) exp_rd = 32'd0;
      check("fault_no_mem_read", 32'(MEM_READ), 32'd0);
      check("fault_no_mem_write", 32'(MEM_WRITE), 32'd0);
      check("fault_done_busy", 32'(BUSYWAIT), 32'd0);
      check("fault_flag", 32'(ACCESS_FAULT), 32'd1);
      check("fault_read_data", READ_DATA, exp_rd);
    end else begin
      n    = ref_nbytes(r, w);
      be_i = (((32'd1 << n) - 32'd1) << (a % 4)) & 32'hF;
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % n) +: 8];
      check("mem_address", 32'(MEM_ADDRESS), a >> 2);
      check("mem_byte_en", 32'(MEM_BYTE_EN), be_i);
      if (w[2]) check("mem_writedata", MEM_WRITEDATA, exp_wd);
      for (int i = 0; i <= dly; i++) begin
        check("access_busy", 32'(BUSYWAIT), 32'd1);
        check("access_mem_read", 32'(MEM_READ), 32'(r[3]));
        check("access_mem_write", 32'(MEM_WRITE), 32'(w[2]));
        if (BUSYWAIT) busy_cycles++;
        if (i == dly) begin
          MEM_ACK      = 1'b1;
          MEM_READDATA = mem_dev[MEM_ADDRESS[3:0]];
          if (MEM_WRITE)
            for (int l = 0; l < 4; l++)
              if (MEM_BYTE_EN[l]) mem_dev[MEM_ADDRESS[3:0]][8*l +: 8] = MEM_WRITEDATA[8*l +: 8];
        end
        @(posedge CLK); #1;
      end
      MEM_ACK = 1'b0;
      MEM_READDATA = $urandom;
      if (r[3]) exp_rd = ref_load(r[2:0], a, mem_ref[idx]);
      else for (int k = 0; k < n; k++) mem_ref[idx][8*(int'(a % 4) + k) +: 8] = wd[8*k +: 8];
      check("done_busy", 32'(BUSYWAIT), 32'd0);
      check("done_mem_read", 32'(MEM_READ), 32'd0);
      check("done_mem_write", 32'(MEM_WRITE), 32'd0);
      check("done_no_fault", 32'(ACCESS_FAULT), 32'd0);
      check("done_read_data", READ_DATA, exp_rd);
    end
    DATA_MEM_READ = 4'd0; DATA_MEM_WRITE = 3'd0;
    @(posedge CLK); #1;
    check("idle_busy", 32'(BUSYWAIT), 32'd0);
    check("idle_fault_clear", 32'(ACCESS_FAULT), 32'd0);
    check("idle_no_request", 32'({MEM_READ, MEM_WRITE}), 32'd0);
  endtask

  // A cycle with no request and a possible stray ack: nothing may change
  task automatic idle_cycle();
    DATA_MEM_READ  = {1'b0, 3'($urandom)};
    DATA_MEM_WRITE = {1'b0, 2'($urandom)};
    ADDRESS        = $urandom;
    MEM_ACK        = 1'($urandom_range(0, 1));
    MEM_READDATA   = $urandom;
    #1;
    check("noreq_busy", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    check("noreq_mem_req", 32'({MEM_READ, MEM_WRITE}), 32'd0);
    check("noreq_fault", 32'(ACCESS_FAULT), 32'd0);
    check("noreq_read_data", READ_DATA, exp_rd);
  endtask

  logic [3:0]  rr;
  logic [2:0]  ww;
  logic [2:0]  lf;
  logic [31:0] aa;
  int          kind;
  int          n_acc;

  initial begin
    DATA_MEM_READ = 4'd0; DATA_MEM_WRITE = 3'd0; ADDRESS = 32'd0; WRITE_DATA = 32'd0;
    MEM_READDATA = 32'd0; MEM_ACK = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ref[i] = $urandom;
      mem_dev[i] = mem_ref[i];
    end

    // Reset values
    #2 RESET = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("rst_read_data", READ_DATA, 32'd0);
    check("rst_fault", 32'(ACCESS_FAULT), 32'd0);
    check("rst_mem_req", 32'({MEM_READ, MEM_WRITE}), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    check("rst_byte_en", 32'(MEM_BYTE_EN), 32'd0);
    check("rst_busy", 32'(BUSYWAIT), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // SW with one wait cycle: three stall cycles
    do_op(4'h0, 3'b110, 32'h100, 32'hDEAD_BEEF, 1);
    check("sw_busy_cycles", busy_cycles, 32'd3);

    // SB then LB/LBU on the top lane
    do_op(4'h0, 3'b100, 32'h103, 32'h0000_0080, 0);
    do_op(4'b1000, 3'd0, 32'h103, 32'd0, 0);
    check("lb_sign", READ_DATA, 32'hFFFF_FF80);
    do_op(4'b1100, 3'd0, 32'h103, 32'd0, 2);
    check("lbu_zero", READ_DATA, 32'h0000_0080);

    // Upper half-word loads
    do_op(4'h0, 3'b110, 32'h200, 32'hBEEF_1234, 0);
    do_op(4'b1101, 3'd0, 32'h202, 32'd0, 0);
    check("lhu_zero", READ_DATA, 32'h0000_BEEF);
    do_op(4'b1001, 3'd0, 32'h202, 32'd0, 1);
    check("lh_sign", READ_DATA, 32'hFFFF_BEEF);

    // Fault cases
    do_op(4'b1010, 3'd0, 32'h101, 32'd0, 0);
    check("lw_misaligned_rd", READ_DATA, 32'd0);
    do_op(4'b1011, 3'd0, 32'h100, 32'd0, 0);
    do_op(4'b1010, 3'b110, 32'h100, 32'h1111_1111, 0);
    do_op(4'h0, 3'b111, 32'h100, 32'h2222_2222, 0);
    do_op(4'h0, 3'b101, 32'h101, 32'h3333_3333, 0);

    // Reset asserted in the middle of an ACCESS
    do_op(4'h0, 3'b110, 32'h10, 32'h1234_5678, 0);
    do_op(4'b1010, 3'd0, 32'h10, 32'd0, 0);
    check("pre_reset_load", READ_DATA, 32'h1234_5678);
    DATA_MEM_READ = 4'b1010; ADDRESS = 32'h10;
    @(posedge CLK); #1;
    check("in_access", 32'(MEM_READ), 32'd1);
    #2 RESET = 1'b0; DATA_MEM_READ = 4'd0;
    #1;
    exp_rd = 32'd0;
    check("arst_mem_read", 32'(MEM_READ), 32'd0);
    check("arst_busy", 32'(BUSYWAIT), 32'd0);
    check("arst_read_data", READ_DATA, 32'd0);
    check("arst_byte_en", 32'(MEM_BYTE_EN), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1; MEM_ACK = 1'b1; MEM_READDATA = $urandom;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    check("stray_ack_mem_read", 32'(MEM_READ), 32'd0);
    check("stray_ack_busy", 32'(BUSYWAIT), 32'd0);
    check("stray_ack_fault", 32'(ACCESS_FAULT), 32'd0);
    check("stray_ack_read_data", READ_DATA, 32'd0);
    idle_cycle();

`ifdef DMEM_TIMEOUT_EN
    // Load that never receives an ack
    DATA_MEM_READ = 4'b1010; ADDRESS = 32'h20;
    @(posedge CLK); #1;
    n_acc = 0;
    while (MEM_READ && n_acc < 20) begin
      n_acc++;
      @(posedge CLK); #1;
    end
    exp_rd = 32'd0;
    check("timeout_access_cycles", n_acc, 32'd4);
    check("timeout_fault", 32'(ACCESS_FAULT), 32'd1);
    check("timeout_read_data", READ_DATA, 32'd0);
    DATA_MEM_READ = 4'd0;
    @(posedge CLK); #1;
`endif

    // Randomized command mix against the reference model
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 11);
      case ($urandom_range(0, 4))
        0:       lf = 3'd0;
        1:       lf = 3'd1;
        2:       lf = 3'd2;
        3:       lf = 3'd4;
        default: lf = 3'd5;
      endcase
      if (kind < 5) begin
        rr = {1'b1, lf};          ww = {1'b0, 2'($urandom)};
      end else if (kind < 10) begin
        rr = {1'b0, 3'($urandom)}; ww = {1'b1, 2'($urandom_range(0, 2))};
      end else if (kind == 10) begin
        rr = {1'b1, 3'($urandom)}; ww = {1'b0, 2'($urandom)};
      end else begin
        rr = {1'b1, 3'($urandom)}; ww = {1'b1, 2'($urandom)};
      end
      aa = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) aa = aa & ~32'd3;
      do_op(rr, ww, aa, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_access_unit.md
# dmem_access_unit

- Sequential memory-side responder for the load/store command word produced by the CPU instruction decoder.
- Consumes DATA_MEM_READ / DATA_MEM_WRITE together with the ALU address and rs2 data.
- Performs byte, half-word or word accesses against a word-organised data memory over a req/ack handshake, stalling the pipeline with BUSYWAIT.
- Returns sign- or zero-extended load data and flags misaligned or illegal accesses.

## Interface
Parameters:
- ADDR_WIDTH, 32: byte-address width; MEM_ADDRESS is ADDR_WIDTH-2 bits.
- TIMEOUT_CYCLES, 255: ack watchdog limit; used only with DMEM_TIMEOUT_EN.

Ports:
- CLK  in  1  rising-edge clock; the block's only clock.
- RESET  in  1  reset, asynchronous and active-low.
- DATA_MEM_READ  in  4  [3] load enable; [2:0] funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- DATA_MEM_WRITE  in  3  [2] store enable; [1:0]: 00 SB, 01 SH, 10 SW.
- ADDRESS  in  ADDR_WIDTH  byte address from the ALU.
- WRITE_DATA  in  32  store data (rs2).
- READ_DATA  out  32  extended load result.
- BUSYWAIT  out  1  pipeline stall request.
- ACCESS_FAULT  out  1  misaligned or illegal access; valid in the DONE cycle only.
- MEM_READ  out  1  memory read request.
- MEM_WRITE  out  1  memory write request.
- MEM_ADDRESS  out  ADDR_WIDTH-2  word address, ADDRESS[ADDR_WIDTH-1:2].
- MEM_WRITEDATA  out  32  lane-replicated store data.
- MEM_BYTE_EN  out  4  byte lane enables.
- MEM_READDATA  in  32  memory read word.
- MEM_ACK  in  1  memory completion; sampled only in ACCESS.

## Operation
- **States:** IDLE, ACCESS, DONE. Reset enters IDLE.
- **Request:** rd = DATA_MEM_READ[3], wr = DATA_MEM_WRITE[2].
- **Fault conditions:**
  - rd and wr both set.
  - Load funct3 is 011, 110 or 111.
  - Store size is 11.
  - Half access with ADDRESS[0]=1.
  - Word access with ADDRESS[1:0]≠00.
- **IDLE, no request:** stay in IDLE.
- **IDLE, request with fault:** go to DONE with the fault latched; no memory cycle.
- **IDLE, legal request:**
  - Register the word address, byte enables, write data, funct3 and ADDRESS[1:0].
  - Go to ACCESS.
- **ACCESS:**
  - MEM_READ or MEM_WRITE is held high, driven from registers.
  - On MEM_ACK=1: a load captures MEM_READDATA into READ_DATA through the extender; go to DONE.
- **DONE:**
  - Requests are ignored for this one cycle, because the pipeline advances on this edge.
  - ACCESS_FAULT reflects the latched fault.
  - Next state is IDLE.
- **Byte enables:**
  - SB/LB/LBU: 4'b0001 << ADDRESS[1:0].
  - SH/LH/LHU: 4'b0011 << {ADDRESS[1],1'b0}.
  - SW/LW: 4'b1111.
- **Store data:** SB → {4{WRITE_DATA[7:0]}}; SH → {2{WRITE_DATA[15:0]}}; SW → WRITE_DATA.
- **Load extract:** select the lane using the registered ADDRESS[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
- **READ_DATA update rules:**
  - Holds until the next completed load.
  - Stores do not modify it.
  - A faulted load sets it to 0.

## Timing
- **BUSYWAIT (combinational):** 1 in IDLE when a request is present, and 1 throughout ACCESS. It is 0 in DONE.
- **Minimum latency** (memory acks in the first ACCESS cycle): 3 cycles.
  - Sequence: IDLE(request) → ACCESS → DONE.
  - BUSYWAIT is high for 2 cycles.
  - READ_DATA is valid from the start of DONE.
- **Faulted access:** 2 cycles, IDLE → DONE, with BUSYWAIT high for 1 cycle.
- **Registered outputs:** MEM_READ and MEM_WRITE rise on the edge entering ACCESS and fall on the edge leaving it.
- **Input stability:** inputs are stable while BUSYWAIT=1 (pipeline stalled); the block does not re-sample them in ACCESS.
- **Reset values:**
  - READ_DATA=0, ACCESS_FAULT=0, MEM_READ=0, MEM_WRITE=0.
  - MEM_ADDRESS=0, MEM_WRITEDATA=0, MEM_BYTE_EN=0.
  - BUSYWAIT=0, state=IDLE.
- **Reset asserted mid-ACCESS:** outputs drop immediately (asynchronous); the in-flight request is abandoned. A late MEM_ACK after reset release is ignored in IDLE.
- **MEM_ACK outside ACCESS:** no effect.

## Configuration
- **DMEM_TIMEOUT_EN defined:**
  - An 8-bit-minimum counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without MEM_ACK.
  - When it reaches TIMEOUT_CYCLES with no ack: drop the request, go to DONE, assert ACCESS_FAULT, and set READ_DATA to 0 for loads.
  - MEM_ACK in the same cycle as the limit is reached wins; completion is normal.
- **DMEM_TIMEOUT_EN undefined:** no counter; ACCESS waits for MEM_ACK indefinitely.

## Test plan
- **SW:** ADDRESS=0x100, WRITE_DATA=0xDEADBEEF, ack after 2 cycles → MEM_WRITE high 2 cycles, MEM_ADDRESS=0x40, MEM_BYTE_EN=1111, BUSYWAIT high 3 cycles, ACCESS_FAULT=0.
- **SB then LB:** SB ADDRESS=0x103, WRITE_DATA=0x80 → MEM_BYTE_EN=1000, MEM_WRITEDATA=0x80808080. LB ADDRESS=0x103 with MEM_READDATA=0x80000000 → READ_DATA=0xFFFFFF80; LBU gives 0x00000080.
- **LHU:** ADDRESS=0x202, MEM_READDATA=0xBEEF1234 → MEM_BYTE_EN=1100, READ_DATA=0x0000BEEF; LH gives 0xFFFFBEEF.
- **Faults:** LW ADDRESS=0x101, or funct3=011, or rd and wr both set → no MEM_READ/MEM_WRITE, BUSYWAIT 1 cycle, ACCESS_FAULT=1 in DONE, READ_DATA=0.
- **Reset mid-access:** RESET low during ACCESS → MEM_READ, BUSYWAIT and READ_DATA go to 0 immediately. After release, a stray MEM_ACK causes no state change.
- **Timeout:** with DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, LW with no ack → ACCESS lasts 4 cycles, then DONE with ACCESS_FAULT=1 and READ_DATA=0.
